// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared constants and helpers for the instruction-fetch stage
//
// Purpose: default address width, the canonical NOP encoding substituted for
// faulting fetches, and a constant-foldable ceil(log2) used to size counters.
// Ports: none (package).
package riscv_pkg;

  localparam int unsigned XLEN_DEFAULT = 32;
  localparam logic [31:0] NOP_INSTR    = 32'h0000_0013;

  // ceil(log2(n)); clog2(1) = 0. Loop bound keeps it elaboration-friendly.
  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - synchronous FIFO with flush and occupancy count
//
// Purpose: generic in-order buffer; used for the outstanding-PC tags and for
// the fetch queue toward decode.
// Ports:
//   clk, rst      clock / asynchronous active-high reset
//   flush         empties the FIFO; wins over push and pop
//   push_i        write push_data_i (ignored when full unless popping)
//   pop_i         remove head (ignored when empty)
//   pop_data_o    head entry (undefined when empty)
//   count_o       number of stored entries, 0..DEPTH
module fetch_fifo
  import riscv_pkg::*;
#(
  parameter type         T     = logic,
  parameter int unsigned DEPTH = 4,
  localparam int unsigned AW   = clog2(DEPTH),
  localparam int unsigned CW   = clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          push_i,
  input  T              push_data_i,
  input  logic          pop_i,
  output T              pop_data_o,
  output logic [CW-1:0] count_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  always_comb begin
    do_pop  = pop_i && (cnt_q != '0);
    do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap naturally.
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      cnt_d = cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage carries no reset; readers qualify the head with count_o.
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem_q[wr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_q];
  assign count_o    = cnt_q;

endmodule

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage with variable-latency memory port
//
// Purpose: holds the PC, issues in-order fetches, pairs responses with their
// PCs and queues {pc, instr, fault} toward decode. Redirects flush all work
// and silently drop responses still owed for the old stream.
// Ports:
//   clk, rst                          clock / asynchronous active-high reset
//   redirect_valid_i, redirect_pc_i   load new PC (low two bits cleared), flush
//   imem_req_valid_o/ready_i/addr_o   fetch request handshake
//   imem_rsp_valid_i/data_i/err_i     in-order fetch response
//   if_valid_o, id_ready_i            decode handshake
//   pc_o, instr_o, fault_o            head entry (NOP substituted on fault)
module if_fetch_unit
  import riscv_pkg::*;
#(
  parameter int unsigned     XLEN       = XLEN_DEFAULT,
  parameter logic [XLEN-1:0] RESET_PC   = '0,
  parameter int unsigned     FBUF_DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_pc_i,
  output logic            imem_req_valid_o,
  input  logic            imem_req_ready_i,
  output logic [XLEN-1:0] imem_req_addr_o,
  input  logic            imem_rsp_valid_i,
  input  logic [31:0]     imem_rsp_data_i,
  input  logic            imem_rsp_err_i,
  output logic            if_valid_o,
  input  logic            id_ready_i,
  output logic [XLEN-1:0] pc_o,
  output logic [31:0]     instr_o,
  output logic            fault_o
);

  localparam int unsigned CW = clog2(FBUF_DEPTH + 1);
  localparam int unsigned SW = CW + 2;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     instr;
    logic            fault;
  } fetch_entry_t;

  logic            rst_q;
  logic [XLEN-1:0] pc_q, pc_d;
  logic [CW-1:0]   inflight_q, inflight_d;
  logic [CW-1:0]   drop_q, drop_d;
  logic [CW-1:0]   tag_count, q_count;
  logic [XLEN-1:0] tag_head;
  fetch_entry_t    q_head, q_push_data;
  logic [SW-1:0]   credit_used;
  logic            req_fire, rsp_drop, rsp_take, q_pop;

  assign if_valid_o      = (q_count != '0);
  assign imem_req_addr_o = pc_q;

  always_comb begin
    // Credits come from registered state only, so the request never depends
    // combinationally on decode readiness or memory responses.
    credit_used      = SW'(inflight_q) + SW'(drop_q) + SW'(q_count);
    imem_req_valid_o = !rst_q && !redirect_valid_i && (credit_used < SW'(FBUF_DEPTH));
    req_fire         = imem_req_valid_o && imem_req_ready_i;
    rsp_drop         = imem_rsp_valid_i && (drop_q != '0);
    rsp_take         = imem_rsp_valid_i && (drop_q == '0) && (inflight_q != '0);
    q_pop            = if_valid_o && id_ready_i && !redirect_valid_i;

    q_push_data.pc    = tag_head;
    q_push_data.instr = imem_rsp_err_i ? NOP_INSTR : imem_rsp_data_i;
    q_push_data.fault = imem_rsp_err_i;

    pc_d       = pc_q;
    inflight_d = inflight_q;
    drop_d     = drop_q;
    if (redirect_valid_i) begin
      pc_d       = redirect_pc_i & ~XLEN'(3);
      inflight_d = '0;
      // Everything still owed by memory becomes junk; a response arriving
      // this very cycle settles one of those debts already.
      drop_d     = drop_q + inflight_q - CW'(rsp_drop || rsp_take);
    end else begin
      if (req_fire) pc_d = pc_q + XLEN'(4);
      inflight_d = inflight_q + CW'(req_fire) - CW'(rsp_take);
      if (rsp_drop) drop_d = drop_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rst_q      <= 1'b1;
      pc_q       <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      rst_q      <= 1'b0;
      pc_q       <= pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.T(logic [XLEN-1:0]), .DEPTH(FBUF_DEPTH)) u_tag_fifo (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid_i),
    .push_i      (req_fire),
    .push_data_i (pc_q),
    .pop_i       (rsp_take),
    .pop_data_o  (tag_head),
    .count_o     (tag_count)
  );

  fetch_fifo #(.T(fetch_entry_t), .DEPTH(FBUF_DEPTH)) u_fetch_queue (
    .clk         (clk),
    .rst         (rst),
    .flush       (redirect_valid_i),
    .push_i      (rsp_take),
    .push_data_i (q_push_data),
    .pop_i       (q_pop),
    .pop_data_o  (q_head),
    .count_o     (q_count)
  );

  // Queue storage is unreset, so present reset-like values whenever empty.
  assign pc_o    = if_valid_o ? q_head.pc    : '0;
  assign instr_o = if_valid_o ? q_head.instr : NOP_INSTR;
  assign fault_o = if_valid_o && q_head.fault;

  a_rsp_expected: assert property (@(posedge clk) disable iff (rst)
    imem_rsp_valid_i |-> (inflight_q != '0 || drop_q != '0));

  a_tag_tracks_inflight: assert property (@(posedge clk) disable iff (rst)
    tag_count == inflight_q);

  a_req_held_stable: assert property (@(posedge clk) disable iff (rst)
    (imem_req_valid_o && !imem_req_ready_i) |=>
      (redirect_valid_i || (imem_req_valid_o && imem_req_addr_o == $past(imem_req_addr_o))));

endmodule

// File: tb/tb_if_fetch_unit.sv
// tb/tb_if_fetch_unit.sv - scoreboard bench for if_fetch_unit
module tb_if_fetch_unit;
  import riscv_pkg::*;

  localparam int          XLEN  = 32;
  localparam logic [31:0] RPC   = 32'h100;
  localparam int          DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        redirect_valid_i = 1'b0;
  logic [31:0] redirect_pc_i = '0;
  logic        imem_req_valid_o;
  logic        imem_req_ready_i = 1'b0;
  logic [31:0] imem_req_addr_o;
  logic        imem_rsp_valid_i = 1'b0;
  logic [31:0] imem_rsp_data_i = '0;
  logic        imem_rsp_err_i = 1'b0;
  logic        if_valid_o;
  logic        id_ready_i = 1'b0;
  logic [31:0] pc_o;
  logic [31:0] instr_o;
  logic        fault_o;

  always #5 clk = ~clk;

  if_fetch_unit #(.XLEN(XLEN), .RESET_PC(RPC), .FBUF_DEPTH(DEPTH)) dut (
    .clk              (clk),
    .rst              (rst),
    .redirect_valid_i (redirect_valid_i),
    .redirect_pc_i    (redirect_pc_i),
    .imem_req_valid_o (imem_req_valid_o),
    .imem_req_ready_i (imem_req_ready_i),
    .imem_req_addr_o  (imem_req_addr_o),
    .imem_rsp_valid_i (imem_rsp_valid_i),
    .imem_rsp_data_i  (imem_rsp_data_i),
    .imem_rsp_err_i   (imem_rsp_err_i),
    .if_valid_o       (if_valid_o),
    .id_ready_i       (id_ready_i),
    .pc_o             (pc_o),
    .instr_o          (instr_o),
    .fault_o          (fault_o)
  );

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] instr; logic fault; } ent_t;

  mreq_t mq[$];
  ent_t  sb[$];

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat_min = 1, lat_max = 1, p_ready = 100, p_id = 100, last_due = 0;
  logic [31:0] next_pc  = RPC;
  logic [31:0] err_addr = 32'hFFFF_FFFF;
  bit          rand_err = 1'b0;
  bit          do_redirect = 1'b0;
  logic [31:0] redir_pc = '0;

  logic        s_req_valid, s_req_fire, s_if_valid, s_if_fire, s_fault;
  logic [31:0] s_addr, s_pc, s_instr;

  function automatic logic [31:0] image(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1357_0000;
  endfunction

  function automatic bit fault_of(input logic [31:0] a);
    return (a == err_addr) || (rand_err && a[6:2] == 5'h13);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, want);
    end
  endtask

  // One clock cycle: drive at the falling edge, sample 1 time unit later,
  // advance the memory/scoreboard model for the coming rising edge.
  task automatic step();
    mreq_t m;
    ent_t  e;
    imem_rsp_valid_i = 1'b0;
    imem_rsp_data_i  = '0;
    imem_rsp_err_i   = 1'b0;
    if (mq.size() != 0 && mq[0].due <= cyc) begin
      imem_rsp_valid_i = 1'b1;
      imem_rsp_data_i  = image(mq[0].addr);
      imem_rsp_err_i   = fault_of(mq[0].addr);
    end
    imem_req_ready_i = ($urandom_range(99) < p_ready);
    id_ready_i       = ($urandom_range(99) < p_id);
    redirect_valid_i = do_redirect;
    redirect_pc_i    = redir_pc;
    #1;
    s_req_valid = imem_req_valid_o;
    s_addr      = imem_req_addr_o;
    s_if_valid  = if_valid_o;
    s_pc        = pc_o;
    s_instr     = instr_o;
    s_fault     = fault_o;
    s_req_fire  = s_req_valid && imem_req_ready_i;
    s_if_fire   = s_if_valid && id_ready_i && !do_redirect;

    if (do_redirect) chk("req_during_redirect", 64'(s_req_valid), 64'd0);
    if (s_req_valid) chk("req_addr", 64'(s_addr), 64'(next_pc));
    if (!s_if_valid) begin
      chk("idle_fault", 64'(s_fault), 64'd0);
      chk("idle_instr", 64'(s_instr), 64'(NOP_INSTR));
    end
    if (s_if_fire) begin
      if (sb.size() == 0) begin
        chk("spurious_valid", 64'(s_if_valid), 64'd0);
      end else begin
        e = sb.pop_front();
        chk("head_pc", 64'(s_pc), 64'(e.pc));
        chk("head_instr", 64'(s_instr), 64'(e.instr));
        chk("head_fault", 64'(s_fault), 64'(e.fault));
      end
    end

    if (imem_rsp_valid_i) void'(mq.pop_front());
    if (do_redirect) begin
      sb.delete();
      next_pc = redir_pc & ~32'h3;
    end else if (s_req_fire) begin
      m.addr = s_addr;
      m.due  = cyc + int'($urandom_range(lat_max, lat_min));
      if (m.due < last_due) m.due = last_due;
      last_due = m.due;
      mq.push_back(m);
      e.pc    = s_addr;
      e.fault = fault_of(s_addr);
      e.instr = e.fault ? NOP_INSTR : image(s_addr);
      sb.push_back(e);
      next_pc = next_pc + 32'd4;
    end
    do_redirect = 1'b0;
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_if_valid"}, 64'(if_valid_o), 64'd0);
    chk({tag, "_fault"}, 64'(fault_o), 64'd0);
    chk({tag, "_req_valid"}, 64'(imem_req_valid_o), 64'd0);
    chk({tag, "_pc"}, 64'(pc_o), 64'd0);
    chk({tag, "_instr"}, 64'(instr_o), 64'(NOP_INSTR));
  endtask

  initial begin
    int n;
    int w;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst = 1'b0;

    // first-request timing after reset release
    step(); chk("t1_rstq_hold", 64'(s_req_valid), 64'd0);
    step(); chk("t1_first_req", 64'(s_req_valid), 64'd1);
            chk("t1_first_addr", 64'(s_addr), 64'h100);
            chk("t1_empty_a", 64'(s_if_valid), 64'd0);
    step(); chk("t1_empty_b", 64'(s_if_valid), 64'd0);
    step(); chk("t1_valid", 64'(s_if_valid), 64'd1);
            chk("t1_pc", 64'(s_pc), 64'h100);

    // streaming with 1-cycle memory: one instruction per cycle
    n = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (s_if_fire) n++;
    end
    chk("t2_no_gaps", 64'(n), 64'd16);

    // decode stall: credit limit reached, nothing lost
    p_id = 0;
    repeat (10) step();
    chk("t3_req_stalled", 64'(s_req_valid), 64'd0);
    chk("t3_outstanding", 64'(sb.size()), 64'(DEPTH));
    chk("t3_head_valid", 64'(s_if_valid), 64'd1);
    p_id = 100;
    repeat (8) step();

    // redirect with responses outstanding on 3-cycle memory
    lat_min = 3; lat_max = 3;
    repeat (12) step();
    do_redirect = 1'b1; redir_pc = 32'h2003;
    step();
    w = 0;
    step();
    while (!s_if_valid && w < 30) begin step(); w++; end
    chk("t4_found", 64'(s_if_valid), 64'd1);
    chk("t4_first_pc", 64'(s_pc), 64'h2000);

    // access fault on 'h108
    lat_min = 1; lat_max = 1;
    err_addr = 32'h108;
    do_redirect = 1'b1; redir_pc = 32'h100;
    step();
    w = 0;
    step();
    while (!(s_if_valid && s_pc == 32'h108) && w < 30) begin step(); w++; end
    chk("t5_found", 64'(s_pc), 64'h108);
    chk("t5_instr", 64'(s_instr), 64'(NOP_INSTR));
    chk("t5_fault", 64'(s_fault), 64'd1);
    step();
    chk("t5_next_pc", 64'(s_pc), 64'h10C);
    chk("t5_next_fault", 64'(s_fault), 64'd0);
    chk("t5_next_instr", 64'(s_instr), 64'(image(32'h10C)));
    repeat (4) step();
    err_addr = 32'hFFFF_FFFF;

    // random latency / backpressure / redirects, with a mid-stream reset
    rand_err = 1'b1;
    lat_min = 1; lat_max = 4; p_ready = 70; p_id = 70;
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(49) == 0) begin
        do_redirect = 1'b1;
        redir_pc    = $urandom;
      end
      step();
      if (i == 5000) begin
        #2 rst = 1'b1;
        #1;
        chk_reset_outputs("midrst");
        mq.delete();
        sb.delete();
        next_pc = RPC;
        last_due = 0;
        do_redirect = 1'b0;
        imem_rsp_valid_i = 1'b0;
        redirect_valid_i = 1'b0;
        @(negedge clk);
        rst = 1'b0;
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
